// File: rtl/wave_segment_sequencer_if.sv
// rtl/wave_segment_sequencer_if.sv - host load/control and generator-bank signal bundle
interface wave_segment_sequencer_if #(
    parameter int CHANNELS = 64,
    parameter int DW       = 16,
    parameter int DEPTH    = 8,
    parameter int TW       = 16
);
    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                   wr_en;
    logic [1:0]             wr_sel;
    logic [DW-1:0]          wr_data;
    logic                   clear;
    logic                   start;
    logic                   stop;
    logic                   loop_mode;
    logic [CHANNELS*DW-1:0] amps;
    logic [CHANNELS*DW-1:0] offsets;
    logic [CHANNELS*DW-1:0] phasewords;
    logic                   gen_reset;
    logic                   gen_active;
    logic [SW-1:0]          seg_index;
    logic [TW-1:0]          time_left;
    logic                   seg_done;
    logic                   seq_done;
    logic [SW:0]            seg_count;
    logic                   full;
    logic                   overflow;

    modport master (
        output wr_en, wr_sel, wr_data, clear, start, stop, loop_mode,
        input  amps, offsets, phasewords, gen_reset, gen_active, seg_index,
               time_left, seg_done, seq_done, seg_count, full, overflow
    );

    modport slave (
        input  wr_en, wr_sel, wr_data, clear, start, stop, loop_mode,
        output amps, offsets, phasewords, gen_reset, gen_active, seg_index,
               time_left, seg_done, seq_done, seg_count, full, overflow
    );
endinterface

// File: rtl/wave_segment_sequencer.sv
// rtl/wave_segment_sequencer.sv - segment table with gapless timed playback into the oscillator bank
module wave_segment_sequencer #(
    parameter int CHANNELS = 64,
    parameter int DW       = 16,
    parameter int DEPTH    = 8,
    parameter int TW       = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    wave_segment_sequencer_if.slave   bus
);
    localparam int SW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CM1 = CHANNELS - 1;
    localparam logic [SW:0]   DEPTH_C   = DEPTH[SW:0];
    localparam logic [SW:0]   CNT_ONE   = 1;
    localparam logic [CW-1:0] LAST_CHAN = CM1[CW-1:0];
    localparam logic [CW-1:0] CHAN_ONE  = 1;
    localparam logic [TW-1:0] TL_ONE    = 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, next_state;

    logic [DW-1:0] amp_mem [DEPTH][CHANNELS];
    logic [DW-1:0] off_mem [DEPTH][CHANNELS];
    logic [DW-1:0] phw_mem [DEPTH][CHANNELS];
    logic [TW-1:0] dur_mem [DEPTH];

    logic [SW:0]            seg_count;
    logic [CW-1:0]          wr_chan;
    logic                   overflow;
    logic                   full;
    logic                   mem_we;
    logic [SW-1:0]          wr_slot;
    logic [CHANNELS*DW-1:0] amps_r, offs_r, phw_r;
    logic [SW-1:0]          seg_index_r;
    logic [TW-1:0]          time_left_r;
    logic                   gen_reset_r, gen_active_r;
    logic [SW:0]            next_slot;
    logic                   do_apply;
    logic [SW-1:0]          apply_slot;
    logic                   seg_done_c, seq_done_c;

    assign full      = (seg_count == DEPTH_C);
    assign wr_slot   = seg_count[SW-1:0];
    assign mem_we    = bus.wr_en && !bus.clear && !full && !reset;
    assign next_slot = {1'b0, seg_index_r} + CNT_ONE;

    // Only slots below seg_count are ever read, so the slot being written never races playback.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            case (bus.wr_sel)
                2'd0: amp_mem[wr_slot][wr_chan] <= bus.wr_data;
                2'd1: off_mem[wr_slot][wr_chan] <= bus.wr_data;
                2'd2: phw_mem[wr_slot][wr_chan] <= bus.wr_data;
                2'd3: dur_mem[wr_slot]          <= bus.wr_data[TW-1:0];
            endcase
        end
    end

    always_comb begin
        next_state = state;
        do_apply   = 1'b0;
        apply_slot = '0;
        seg_done_c = 1'b0;
        seq_done_c = 1'b0;
        if (!reset) begin
            if (bus.clear || bus.stop) begin
                next_state = IDLE;
            end else if (bus.start) begin
                if (seg_count != '0) begin
                    do_apply   = 1'b1;
                    next_state = RUN;
                end
            end else if (state == RUN && time_left_r == '0) begin
                seg_done_c = 1'b1;
                if (next_slot < seg_count) begin
                    do_apply   = 1'b1;
                    apply_slot = next_slot[SW-1:0];
                end else if (bus.loop_mode) begin
                    do_apply   = 1'b1;
                end else begin
                    seq_done_c = 1'b1;
                    next_state = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            seg_count    <= '0;
            wr_chan      <= '0;
            overflow     <= 1'b0;
            amps_r       <= '0;
            offs_r       <= '0;
            phw_r        <= '0;
            seg_index_r  <= '0;
            time_left_r  <= '0;
            gen_reset_r  <= 1'b0;
            gen_active_r <= 1'b0;
        end else begin
            state        <= next_state;
            gen_reset_r  <= do_apply;
            gen_active_r <= (next_state == RUN);
            if (do_apply) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    amps_r[k*DW +: DW] <= amp_mem[apply_slot][k];
                    offs_r[k*DW +: DW] <= off_mem[apply_slot][k];
                    phw_r[k*DW +: DW]  <= phw_mem[apply_slot][k];
                end
                seg_index_r <= apply_slot;
                time_left_r <= dur_mem[apply_slot];
            end else if (state == RUN && next_state == RUN) begin
                time_left_r <= time_left_r - TL_ONE;
            end

            if (bus.clear) begin
                seg_count <= '0;
                wr_chan   <= '0;
                overflow  <= 1'b0;
            end else if (bus.wr_en) begin
                if (full) begin
                    overflow <= 1'b1;
                end else if (bus.wr_sel == 2'd3) begin
                    seg_count <= seg_count + CNT_ONE;
                    wr_chan   <= '0;
                end else if (bus.wr_sel == 2'd2) begin
                    wr_chan <= (wr_chan == LAST_CHAN) ? '0 : wr_chan + CHAN_ONE;
                end
            end
        end
    end

    assign bus.amps       = amps_r;
    assign bus.offsets    = offs_r;
    assign bus.phasewords = phw_r;
    assign bus.gen_reset  = gen_reset_r;
    assign bus.gen_active = gen_active_r;
    assign bus.seg_index  = seg_index_r;
    assign bus.time_left  = time_left_r;
    assign bus.seg_done   = seg_done_c;
    assign bus.seq_done   = seq_done_c;
    assign bus.seg_count  = seg_count;
    assign bus.full       = full;
    assign bus.overflow   = overflow;
endmodule

// File: tb/tb_wave_segment_sequencer.sv
// tb/tb_wave_segment_sequencer.sv - randomized and directed bench with a playback-schedule model
module tb_wave_segment_sequencer;
    localparam int CH    = 64;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int TW    = 16;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    wave_segment_sequencer_if #(.CHANNELS(CH), .DW(DW), .DEPTH(DEPTH), .TW(TW)) bus ();

    wave_segment_sequencer #(.CHANNELS(CH), .DW(DW), .DEPTH(DEPTH), .TW(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    // Model: table contents plus a schedule of (slot, cycles elapsed since apply).
    logic [DW-1:0]    t_amp [DEPTH][CH];
    logic [DW-1:0]    t_off [DEPTH][CH];
    logic [DW-1:0]    t_ph  [DEPTH][CH];
    int               t_dur [DEPTH];
    int               m_cnt, m_chan, m_slot, m_elapsed, m_dur;
    bit               m_ovf, m_active, m_genrst, m_valid = 0;
    logic [CH*DW-1:0] m_amps, m_offs, m_phs;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_vec(input string name, input logic [CH*DW-1:0] got, input logic [CH*DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            for (int k = 0; k < CH; k++) begin
                if (got[k*DW +: DW] !== exp[k*DW +: DW]) begin
                    $display("FAIL %s ch%0d: got %0h expected %0h at %0t", name, k,
                             got[k*DW +: DW], exp[k*DW +: DW], $time);
                    break;
                end
            end
        end
    endtask

    task automatic model_step();
        int apply;
        bit last;
        if (reset) begin
            m_cnt = 0; m_chan = 0; m_ovf = 0; m_active = 0; m_genrst = 0;
            m_slot = 0; m_elapsed = 0; m_dur = 0;
            m_amps = '0; m_offs = '0; m_phs = '0;
            m_valid = 1;
            return;
        end
        last  = m_active && (m_elapsed == m_dur);
        apply = -1;
        if (bus.clear || bus.stop) m_active = 0;
        else if (bus.start) begin
            if (m_active || m_cnt > 0) apply = 0;
        end else if (last) begin
            if (m_slot + 1 < m_cnt) apply = m_slot + 1;
            else if (bus.loop_mode) apply = 0;
            else m_active = 0;
        end else if (m_active) m_elapsed++;
        m_genrst = (apply >= 0);
        if (apply >= 0) begin
            m_slot = apply; m_elapsed = 0; m_dur = t_dur[apply]; m_active = 1;
            for (int k = 0; k < CH; k++) begin
                m_amps[k*DW +: DW] = t_amp[apply][k];
                m_offs[k*DW +: DW] = t_off[apply][k];
                m_phs[k*DW +: DW]  = t_ph[apply][k];
            end
        end
        if (bus.clear) begin
            m_cnt = 0; m_chan = 0; m_ovf = 0;
        end else if (bus.wr_en) begin
            if (m_cnt == DEPTH) m_ovf = 1;
            else case (bus.wr_sel)
                2'd0: t_amp[m_cnt][m_chan] = bus.wr_data;
                2'd1: t_off[m_cnt][m_chan] = bus.wr_data;
                2'd2: begin t_ph[m_cnt][m_chan] = bus.wr_data; m_chan = (m_chan + 1) % CH; end
                2'd3: begin t_dur[m_cnt] = int'(bus.wr_data[TW-1:0]); m_cnt++; m_chan = 0; end
            endcase
        end
    endtask

    always @(negedge clk) begin
        bit exp_seg, exp_seq;
        if (m_valid) begin
            exp_seg = !reset && !bus.clear && !bus.stop && !bus.start &&
                      m_active && (m_elapsed == m_dur);
            exp_seq = exp_seg && (m_slot + 1 >= m_cnt) && !bus.loop_mode;
            chk("gen_active", 64'(bus.gen_active), 64'(m_active));
            chk("gen_reset",  64'(bus.gen_reset),  64'(m_genrst));
            chk("seg_index",  64'(bus.seg_index),  64'(m_slot));
            chk("time_left",  64'(bus.time_left),  64'(m_dur - m_elapsed));
            chk("seg_count",  64'(bus.seg_count),  64'(m_cnt));
            chk("full",       64'(bus.full),       64'(m_cnt == DEPTH));
            chk("overflow",   64'(bus.overflow),   64'(m_ovf));
            chk("seg_done",   64'(bus.seg_done),   64'(exp_seg));
            chk("seq_done",   64'(bus.seq_done),   64'(exp_seq));
            chk_vec("amps",       bus.amps,       m_amps);
            chk_vec("offsets",    bus.offsets,    m_offs);
            chk_vec("phasewords", bus.phasewords, m_phs);
        end
        model_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [DW-1:0] data);
        bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_data = data;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic write_channels(output logic [CH*DW-1:0] amps_out);
        logic [DW-1:0] a;
        for (int k = 0; k < CH; k++) begin
            a = DW'($urandom);
            amps_out[k*DW +: DW] = a;
            wr(2'd0, a);
            wr(2'd1, DW'($urandom));
            wr(2'd2, DW'($urandom));
        end
    endtask

    task automatic pulse_start(); bus.start = 1'b1; tick(); bus.start = 1'b0; endtask
    task automatic pulse_stop();  bus.stop  = 1'b1; tick(); bus.stop  = 1'b0; endtask
    task automatic pulse_clear(); bus.clear = 1'b1; tick(); bus.clear = 1'b0; endtask

    initial begin
        logic [CH*DW-1:0] seg0_amps, seg1_amps;
        int n_act, n_idx1, n_seq, n_grst, n_amp0, seq_at, last_act, n_bad, n_done;

        reset = 1'b1;
        bus.wr_en = 0; bus.wr_sel = 0; bus.wr_data = 0;
        bus.clear = 0; bus.start = 0; bus.stop = 0; bus.loop_mode = 0;
        tick(); tick();
        reset = 1'b0;

        @(negedge clk);
        chk("rst_gen_active", 64'(bus.gen_active), 64'd0);
        chk("rst_seg_count",  64'(bus.seg_count),  64'd0);
        chk("rst_overflow",   64'(bus.overflow),   64'd0);
        chk("rst_amps_zero",  64'(bus.amps == '0), 64'd1);
        pulse_start();
        @(negedge clk);
        chk("empty_start_idle", 64'(bus.gen_active), 64'd0);

        // Two segments, durations 3 and 0, one-shot playback.
        write_channels(seg0_amps); wr(2'd3, 16'd3);
        write_channels(seg1_amps); wr(2'd3, 16'd0);
        @(negedge clk);
        chk("two_loaded", 64'(bus.seg_count), 64'd2);
        pulse_start();
        n_act = 0; n_idx1 = 0; n_seq = 0; n_grst = 0; n_amp0 = 0; seq_at = -1; last_act = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) chk("first_gen_reset", 64'(bus.gen_reset), 64'd1);
            if (bus.gen_active) begin n_act++; last_act = i; end
            if (bus.gen_active && bus.seg_index == 1) n_idx1++;
            if (bus.gen_active && bus.seg_index == 0 && bus.amps == seg0_amps) n_amp0++;
            if (bus.seq_done) begin n_seq++; seq_at = i; end
            if (bus.gen_reset) n_grst++;
        end
        chk("oneshot_active_cycles", 64'(n_act),  64'd5);
        chk("oneshot_seg0_cycles",   64'(n_amp0), 64'd4);
        chk("oneshot_seg1_cycles",   64'(n_idx1), 64'd1);
        chk("oneshot_seq_done_cnt",  64'(n_seq),  64'd1);
        chk("oneshot_seq_at_last",   64'(seq_at), 64'(last_act));
        chk("oneshot_gen_resets",    64'(n_grst), 64'd2);

        // Looping: index pattern 0,0,0,0,1 repeating, gen_reset on each change.
        bus.loop_mode = 1'b1;
        pulse_start();
        n_bad = 0; n_seq = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.seg_index != ((i % 5 == 4) ? 1 : 0)) n_bad++;
            if (bus.gen_reset != ((i % 5 == 0) || (i % 5 == 4))) n_bad++;
            if (bus.seq_done) n_seq++;
        end
        chk("loop_pattern_errs", 64'(n_bad), 64'd0);
        chk("loop_no_seq_done",  64'(n_seq), 64'd0);
        pulse_stop();
        bus.loop_mode = 1'b0;

        // Stop while time_left is 2, then replay from segment 0.
        pulse_start();
        tick();
        bus.stop = 1'b1;
        @(negedge clk);
        chk("stop_at_tl2", 64'(bus.time_left), 64'd2);
        tick();
        bus.stop = 1'b0;
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) chk("stop_inactive", 64'(bus.gen_active), 64'd0);
            if (bus.seg_done || bus.seq_done) n_done++;
        end
        chk("stop_no_done", 64'(n_done), 64'd0);
        pulse_start();
        @(negedge clk);
        chk("replay_index", 64'(bus.seg_index), 64'd0);
        chk("replay_tl",    64'(bus.time_left), 64'd3);
        pulse_stop();

        // Append seg 1 while seg 0 (duration 10) is playing.
        pulse_clear();
        write_channels(seg0_amps); wr(2'd3, 16'd10);
        write_channels(seg1_amps);
        pulse_start();
        tick(); tick();
        wr(2'd3, 16'd2);
        for (int i = 0; i < 8; i++) tick();
        @(negedge clk);
        chk("append_index",  64'(bus.seg_index), 64'd1);
        chk("append_gapless", 64'({bus.gen_active, bus.gen_reset}), 64'd3);
        chk_vec("append_amps", bus.amps, seg1_amps);
        tick(); tick();
        bus.start = 1'b1;
        @(negedge clk);
        chk("collide_tl0",     64'(bus.time_left), 64'd0);
        chk("collide_no_done", 64'({bus.seg_done, bus.seq_done}), 64'd0);
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        chk("collide_restart", 64'({bus.seg_index, bus.gen_reset}), 64'd1);
        chk("collide_tl",      64'(bus.time_left), 64'd10);
        pulse_stop();

        // DEPTH+1 commits: full after DEPTH, extra words dropped, clear recovers.
        pulse_clear();
        for (int i = 0; i < DEPTH; i++) wr(2'd3, DW'(i));
        @(negedge clk);
        chk("fill_full",     64'({bus.full, bus.overflow}), 64'd2);
        wr(2'd0, 16'h1234);
        wr(2'd3, 16'd1);
        @(negedge clk);
        chk("ovf_set",   64'(bus.overflow),  64'd1);
        chk("ovf_count", 64'(bus.seg_count), 64'(DEPTH));
        pulse_clear();
        @(negedge clk);
        chk("clear_state", 64'({bus.seg_count, bus.overflow, bus.full}), 64'd0);

        // Randomized traffic; the per-cycle model comparison does the checking.
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 999) == 0);
            bus.clear = ($urandom_range(0, 199) == 0);
            bus.stop  = ($urandom_range(0, 79) == 0);
            bus.start = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 99) == 0) bus.loop_mode = ~bus.loop_mode;
            bus.wr_en  = ($urandom_range(0, 2) == 0);
            bus.wr_sel = 2'($urandom_range(0, 3));
            bus.wr_data = (bus.wr_sel == 2'd3) ? DW'($urandom_range(0, 6)) : DW'($urandom);
            tick();
        end
        reset = 0; bus.clear = 0; bus.stop = 0; bus.start = 0; bus.wr_en = 0;
        tick(); tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
